// File: rtl/mm_skew_feeder_if.sv
// Beat bus for mm_skew_feeder: skewed lane outputs and the input handshake.
// The out_stall signal exists only when MM_FEEDER_STALL_EN is defined.
interface mm_skew_feeder_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           busy;
  logic           done;
`ifdef MM_FEEDER_STALL_EN
  logic           out_stall;

  modport slave (
    input  in_data, in_valid, in_last, out_stall,
    output in_ready, out_data, out_valid, busy, done
  );
  modport master (
    output in_data, in_valid, in_last, out_stall,
    input  in_ready, out_data, out_valid, busy, done
  );
`else
  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_data, out_valid, busy, done
  );
  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_data, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/mm_skew_feeder.sv
// Skews one operand matrix into the systolic array: lane i delays each beat by i extra cycles.
// Optional output stall is enabled by defining MM_FEEDER_STALL_EN.
module mm_skew_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  mm_skew_feeder_if.slave  bus
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]     state_reg, state_next;
  logic [CW-1:0]  flush_cnt_reg, flush_cnt_next;
  logic           done_reg, done_next;
  logic           stall;
  logic           accept;
  logic [N*W-1:0] lane_data;
  logic [N-1:0]   lane_valid;

`ifdef MM_FEEDER_STALL_EN
  assign stall = bus.out_stall;
`else
  assign stall = 1'b0;
`endif

  assign bus.in_ready  = (state_reg != ST_FLUSH) && !stall;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;
  assign bus.out_data  = lane_data;
  assign bus.out_valid = lane_valid;

  // done is raised on the edge where lane N-1 receives the final beat.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    done_next      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (bus.in_last) begin
            if (N == 1) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next     = ST_FLUSH;
              flush_cnt_next = CW'(N - 1);
            end
          end else begin
            state_next = ST_STREAM;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt_reg - CW'(1);
        if (flush_cnt_reg == CW'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else if (!stall) begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      done_reg      <= done_next;
    end
  end

  // Lane gi is a chain of gi+1 stages; non-accept cycles load a zero bubble.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0] data_reg  [0:gi];
      logic         valid_reg [0:gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s <= gi; s++) begin
            data_reg[s]  <= '0;
            valid_reg[s] <= 1'b0;
          end
        end else if (!stall) begin
          data_reg[0]  <= accept ? bus.in_data[gi*W +: W] : '0;
          valid_reg[0] <= accept;
          for (int s = 1; s <= gi; s++) begin
            data_reg[s]  <= data_reg[s-1];
            valid_reg[s] <= valid_reg[s-1];
          end
        end
      end

      assign lane_data[gi*W +: W] = data_reg[gi];
      assign lane_valid[gi]       = valid_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_mm_skew_feeder.sv
// Scoreboard bench for mm_skew_feeder (N=4, W=8); the stall scenario runs when
// MM_FEEDER_STALL_EN is defined.
module tb_mm_skew_feeder;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mm_skew_feeder_if #(.N(N), .W(W)) bus ();

  mm_skew_feeder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  bit sb_on = 1'b0;
  bit rst_tb = 1'b0;
  bit stall_tb = 1'b0;

  // Per-lane expected {valid, data}, one entry per non-stalled edge.
  logic [W:0] lane_q [N][$];
  logic       exp_v [N];
  logic [W-1:0] exp_d [N];

  function automatic logic [N*W-1:0] mk(input int base, input int k);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + 16 * k + i);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb_on) begin
      if (rst_tb) begin
        for (int i = 0; i < N; i++) begin
          exp_v[i] = 1'b0;
          exp_d[i] = '0;
        end
      end else if (!stall_tb) begin
        for (int i = 0; i < N; i++) begin
          if (lane_q[i].size() == 0) begin
            errors++;
            $display("FAIL sb_underflow lane%0d: queue empty, required an entry", i);
          end else begin
            logic [W:0] e;
            e = lane_q[i].pop_front();
            exp_v[i] = e[W];
            exp_d[i] = e[W-1:0];
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.out_valid[i] !== exp_v[i] || bus.out_data[i*W +: W] !== exp_d[i]) begin
          errors++;
          $display("FAIL lane%0d t=%0t: got v=%b d=%h, required v=%b d=%h", i, $time,
                   bus.out_valid[i], bus.out_data[i*W +: W], exp_v[i], exp_d[i]);
        end
      end
      if (bus.done === 1'b1) done_count++;
    end
  end

  task automatic cycle(input bit valid, input bit last, input logic [N*W-1:0] data,
                       input bit acc, input bit stall);
    logic [W:0] e;
    @(negedge clk);
    reset = 1'b0;
    rst_tb = 1'b0;
    bus.in_valid = valid;
    bus.in_last = last;
    bus.in_data = data;
`ifdef MM_FEEDER_STALL_EN
    bus.out_stall = stall;
`endif
    stall_tb = stall;
    if (!stall) begin
      for (int i = 0; i < N; i++) begin
        e = acc ? {1'b1, data[i*W +: W]} : '0;
        lane_q[i].push_back(e);
      end
    end
    $display("cycle t=%0t v=%b l=%b acc=%b stall=%b rdy=%b ov=%b done=%b", $time, valid, last,
             acc, stall, bus.in_ready, bus.out_valid, bus.done);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset = 1'b1;
      rst_tb = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.in_data = '0;
`ifdef MM_FEEDER_STALL_EN
      bus.out_stall = 1'b0;
`endif
      stall_tb = 1'b0;
      for (int i = 0; i < N; i++) begin
        lane_q[i].delete();
        for (int b = 0; b < i; b++) lane_q[i].push_back('0);
      end
      sb_on = 1'b1;
      $display("reset t=%0t", $time);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (bus.out_valid !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h, required 0/0", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: got rdy=%b busy=%b done=%b, required 1 0 0",
               bus.in_ready, bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_count;
    logic exp_rdy;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, k == 3, mk(0, k), 1'b1, 1'b0);
      exp_rdy = (k != 3);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_beat%0d: got busy=%b rdy=%b, required 1 %b", k, bus.busy,
                 bus.in_ready, exp_rdy);
      end
    end
    // A beat offered during the drain must be ignored.
    for (int j = 0; j < 3; j++) begin
      cycle(j == 0, 1'b0, mk(0, 9), 1'b0, 1'b0);
      exp_rdy = (j == 2);
      checks++;
      if (bus.in_ready !== exp_rdy || bus.done !== exp_rdy || bus.busy !== !exp_rdy) begin
        errors++;
        $display("FAIL b2b_flush%0d: got rdy=%b done=%b busy=%b, required %b %b %b", j,
                 bus.in_ready, bus.done, bus.busy, exp_rdy, exp_rdy, !exp_rdy);
      end
    end
    checks++;
    if (bus.out_valid[N-1] !== 1'b1 || bus.out_data[(N-1)*W +: W] !== 8'h33) begin
      errors++;
      $display("FAIL b2b_last_lane: got v=%b d=%h, required 1 33", bus.out_valid[N-1],
               bus.out_data[(N-1)*W +: W]);
    end
    idle(1);
    checks++;
    if (bus.done !== 1'b0 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL b2b_done_once: got done=%b pulses=%0d, required 0 1", bus.done,
               done_count - d0);
    end
  endtask

  task automatic test_gap();
    cycle(1'b1, 1'b0, mk(8'h40, 0), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_stream: got rdy=%b busy=%b, required 1 1", bus.in_ready, bus.busy);
    end
    cycle(1'b1, 1'b1, mk(8'h40, 2), 1'b1, 1'b0);
    idle(3);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL gap_done: got %b, required 1", bus.done);
    end
    idle(1);
  endtask

  task automatic test_overlap();
    int d0 = done_count;
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 3, mk(0, k), 1'b1, 1'b0);
    idle(3);
    checks++;
    if (bus.done !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovl_done_a: got done=%b rdy=%b, required 1 1", bus.done, bus.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, k == 3, mk(8'h80, k), 1'b1, 1'b0);
      if (k == 0) begin
        checks++;
        if (bus.done !== 1'b0 || bus.out_valid[0] !== 1'b1 || bus.out_data[W-1:0] !== 8'h80) begin
          errors++;
          $display("FAIL ovl_lane0_b: got done=%b v=%b d=%h, required 0 1 80", bus.done,
                   bus.out_valid[0], bus.out_data[W-1:0]);
        end
      end
    end
    idle(3);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL ovl_done_b: got %b, required 1", bus.done);
    end
    idle(1);
    checks++;
    if (done_count - d0 != 2) begin
      errors++;
      $display("FAIL ovl_pulses: got %0d, required 2", done_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_count;
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 3, mk(8'hC0, k), 1'b1, 1'b0);
    idle(1);
    checks++;
    if (bus.out_valid[3:2] !== 2'b11 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: got v=%b busy=%b, required 11 1", bus.out_valid[3:2], bus.busy);
    end
    do_reset(1);
    checks++;
    if (bus.out_valid !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_post: got v=%b busy=%b rdy=%b, required 0 0 1", bus.out_valid,
               bus.busy, bus.in_ready);
    end
    idle(6);
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL rmid_no_done: got %0d pulses, required 0", done_count - d0);
    end
  endtask

`ifdef MM_FEEDER_STALL_EN
  task automatic test_stall();
    cycle(1'b1, 1'b0, mk(8'h20, 0), 1'b1, 1'b0);
    cycle(1'b1, 1'b0, mk(8'h20, 1), 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 1'b0, mk(8'h20, 2), 1'b0, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_rdy%0d: got rdy=%b busy=%b, required 0 1", s, bus.in_ready,
                 bus.busy);
      end
    end
    cycle(1'b1, 1'b0, mk(8'h20, 2), 1'b1, 1'b0);
    cycle(1'b1, 1'b1, mk(8'h20, 3), 1'b1, 1'b0);
    idle(3);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got %b, required 1", bus.done);
    end
    for (int s = 0; s < 2; s++) begin
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (bus.done !== 1'b1) begin
        errors++;
        $display("FAIL stall_done_hold%0d: got %b, required 1", s, bus.done);
      end
    end
    idle(1);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_done_drop: got %b, required 0", bus.done);
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
`ifdef MM_FEEDER_STALL_EN
    bus.out_stall = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_gap();
    test_overlap();
    test_reset_mid();
`ifdef MM_FEEDER_STALL_EN
    test_stall();
`endif
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
